// File: rtl/mc_controller.sv
// Multicycle ARM-subset control unit.
// Main FSM, ALU decode, condition check and flag register.
module mc_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic        ALUSrcA,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  ALUControl
);

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXER,
    EXEI,
    ALUWB,
    BRANCH,
    UNKNOWN
  } state_t;

  state_t     state;
  state_t     state_n;
  logic [1:0] op;
  logic [3:0] cond;
  logic [3:0] cmd;
  logic       ibit;
  logic       sbit;
  logic       rd_pc;
  logic [3:0] flags;
  logic       fn;
  logic       fz;
  logic       fc;
  logic       fv;
  logic       condex;
  logic       condexr;
  logic [1:0] alu_op;
  logic       alu_known;
  logic       alu_arith;
  logic       exe;
  logic       flag_upd;
  logic       unused_bits;

  assign op    = Instr[27:26];
  assign cond  = Instr[31:28];
  assign cmd   = Instr[24:21];
  assign ibit  = Instr[25];
  assign sbit  = Instr[20];
  assign rd_pc = (Instr[15:12] == 4'hF);

  assign unused_bits = ^{Instr[19:16], Instr[11:0]};

  assign {fn, fz, fc, fv} = flags;

  always_comb begin
    condex = 1'b0;
    unique case (cond)
      4'h0: condex = fz;
      4'h1: condex = ~fz;
      4'h2: condex = fc;
      4'h3: condex = ~fc;
      4'h4: condex = fn;
      4'h5: condex = ~fn;
      4'h6: condex = fv;
      4'h7: condex = ~fv;
      4'h8: condex = fc & ~fz;
      4'h9: condex = ~fc | fz;
      4'hA: condex = (fn == fv);
      4'hB: condex = (fn != fv);
      4'hC: condex = ~fz & (fn == fv);
      4'hD: condex = fz | (fn != fv);
      4'hE: condex = 1'b1;
      4'hF: condex = 1'b0;
    endcase
  end

  // Unsupported commands fall back to ADD but never touch the flags.
  always_comb begin
    alu_op    = 2'b00;
    alu_known = 1'b1;
    case (cmd)
      4'b0100: alu_op = 2'b00;
      4'b0010: alu_op = 2'b01;
      4'b0000: alu_op = 2'b10;
      4'b1100: alu_op = 2'b11;
      default: alu_known = 1'b0;
    endcase
  end

  assign alu_arith = (cmd == 4'b0100) | (cmd == 4'b0010);
  assign exe       = (state == EXER) | (state == EXEI);
  assign flag_upd  = exe & condexr & sbit & alu_known;

  always_comb begin
    state_n = FETCH;
    unique case (state)
      FETCH:   state_n = DECODE;
      DECODE: begin
        unique case (op)
          2'b00: state_n = ibit ? EXEI : EXER;
          2'b01: state_n = MEMADR;
          2'b10: state_n = BRANCH;
          2'b11: state_n = UNKNOWN;
        endcase
      end
      MEMADR:  state_n = sbit ? MEMRD : MEMWR;
      MEMRD:   state_n = MEMWB;
      EXER:    state_n = ALUWB;
      EXEI:    state_n = ALUWB;
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      flags   <= 4'b0000;
      condexr <= 1'b0;
    end else begin
      state <= state_n;
      if (state == DECODE)
        condexr <= condex;
      if (flag_upd) begin
        flags[3:2] <= ALUFlags[3:2];
        if (alu_arith)
          flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  always_comb begin
    PCWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 2'b00;
    unique case (state)
      FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR: ALUSrcB = 2'b01;
      MEMRD:  AdrSrc  = 1'b1;
      MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = condexr;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = condexr;
        PCWrite   = condexr & rd_pc;
      end
      EXER: ALUControl = alu_op;
      EXEI: begin
        ALUSrcB    = 2'b01;
        ALUControl = alu_op;
      end
      ALUWB: begin
        RegWrite = condexr;
        PCWrite  = condexr & rd_pc;
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = condexr;
      end
      default: ;
    endcase
    // Reset kills every enable, even mid-instruction.
    if (reset) begin
      PCWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      IRWrite  = 1'b0;
    end
  end

  assign ImmSrc = op;
  assign RegSrc = {op == 2'b01, op == 2'b10};

endmodule
